// File: rtl/tick_gen_pkg.sv
// Shared constants for the multi-channel tick generator: default widths and rates,
// the chess-clock channel assignments and a divisor-from-rate helper.
package tick_gen_pkg;

   localparam int unsigned INPUT_FREQUENCY_DEFAULT = 50_000_000;
   localparam int          COUNT_WIDTH_DEFAULT     = 26;
   localparam int unsigned DEFAULT_DIVISOR         = INPUT_FREQUENCY_DEFAULT;

   localparam int CH_WHITE = 0;
   localparam int CH_BLACK = 1;

   // A zero rate would divide by zero, so it falls back to a 1 Hz divisor.
   function automatic int unsigned div_for_hz(input int unsigned freq);
      return (freq == 0) ? INPUT_FREQUENCY_DEFAULT : INPUT_FREQUENCY_DEFAULT / freq;
   endfunction

endpackage

// File: rtl/tick_channel.sv
// One divided timebase: counter, active/pending divisor and the registered
// tick strobe and square wave. A new divisor only takes effect at a wrap or clear.
module tick_channel
   import tick_gen_pkg::*;
#(
   parameter int COUNT_WIDTH     = COUNT_WIDTH_DEFAULT,
   parameter int DEFAULT_DIVISOR = tick_gen_pkg::DEFAULT_DIVISOR
) (
   input  logic                   InClock,
   input  logic                   reset,
   input  logic                   run,
   input  logic                   clear,
   input  logic                   divLoad,
   input  logic [COUNT_WIDTH-1:0] divIn,
   output logic                   tick,
   output logic                   square,
   output logic                   zeroLoad
);

   localparam logic [COUNT_WIDTH-1:0] RESET_DIV = COUNT_WIDTH'(DEFAULT_DIVISOR);
   localparam logic [COUNT_WIDTH-1:0] ONE       = COUNT_WIDTH'(1);

   logic [COUNT_WIDTH-1:0] count;
   logic [COUNT_WIDTH-1:0] activeDiv;
   logic [COUNT_WIDTH-1:0] pendingDiv;
   logic                   pendingValid;
   logic                   loadOk;
   logic                   wrap;

   assign loadOk   = divLoad && (divIn != '0);
   assign zeroLoad = divLoad && (divIn == '0);
   assign wrap     = (count == activeDiv - ONE);

   always_ff @(posedge InClock or posedge reset) begin
      if (reset) begin
         count        <= '0;
         activeDiv    <= RESET_DIV;
         pendingDiv   <= '0;
         pendingValid <= 1'b0;
         tick         <= 1'b0;
         square       <= 1'b0;
      end else if (clear) begin
         count        <= '0;
         tick         <= 1'b0;
         square       <= 1'b0;
         pendingValid <= 1'b0;
         // A load arriving with the clear is newer than anything still pending.
         if (loadOk)
            activeDiv <= divIn;
         else if (pendingValid)
            activeDiv <= pendingDiv;
      end else begin
         tick <= 1'b0;
         if (run) begin
            if (wrap) begin
               count  <= '0;
               tick   <= 1'b1;
               square <= ~square;
               if (pendingValid) begin
                  activeDiv    <= pendingDiv;
                  pendingValid <= 1'b0;
               end
            end else begin
               count <= count + ONE;
            end
         end
         // Placed last so a load coinciding with a wrap stays pending.
         if (loadOk) begin
            pendingDiv   <= divIn;
            pendingValid <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/multi_channel_tick_generator.sv
// NUM_CHANNELS independent tick/square timebases sharing one divisor bus,
// plus a sticky flag for any attempt to load a zero divisor.
module multi_channel_tick_generator
   import tick_gen_pkg::*;
#(
   parameter int INPUT_FREQUENCY = INPUT_FREQUENCY_DEFAULT,
   parameter int NUM_CHANNELS    = 2,
   parameter int COUNT_WIDTH     = COUNT_WIDTH_DEFAULT,
   parameter int DEFAULT_DIVISOR = INPUT_FREQUENCY
) (
   input  logic                    InClock,
   input  logic                    reset,
   input  logic [NUM_CHANNELS-1:0] run,
   input  logic [NUM_CHANNELS-1:0] clear,
   input  logic [NUM_CHANNELS-1:0] div_load,
   input  logic [COUNT_WIDTH-1:0]  div_in,
   output logic [NUM_CHANNELS-1:0] tick,
   output logic [NUM_CHANNELS-1:0] square,
   output logic                    div_err
);

   logic [NUM_CHANNELS-1:0] zeroLoad;

   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : gChannel
      tick_channel #(
         .COUNT_WIDTH     (COUNT_WIDTH),
         .DEFAULT_DIVISOR (DEFAULT_DIVISOR)
      ) uChannel (
         .InClock  (InClock),
         .reset    (reset),
         .run      (run[i]),
         .clear    (clear[i]),
         .divLoad  (div_load[i]),
         .divIn    (div_in),
         .tick     (tick[i]),
         .square   (square[i]),
         .zeroLoad (zeroLoad[i])
      );
   end

   always_ff @(posedge InClock or posedge reset) begin
      if (reset)
         div_err <= 1'b0;
      else if (|zeroLoad)
         div_err <= 1'b1;
   end

endmodule

// File: tb/tb_multi_channel_tick_generator.sv
// Directed bench for the tick generator: period, divisor reload, pause,
// clear-with-load, zero-divisor error and asynchronous reset.
module tb_multi_channel_tick_generator;

   logic       InClock;
   logic       reset;
   logic [1:0] run;
   logic [1:0] clear;
   logic [1:0] divLoad;
   logic [7:0] divIn;
   logic [1:0] tick;
   logic [1:0] square;
   logic       divErr;

   int checks = 0;
   int errors = 0;

   multi_channel_tick_generator #(
      .INPUT_FREQUENCY (50),
      .NUM_CHANNELS    (2),
      .COUNT_WIDTH     (8),
      .DEFAULT_DIVISOR (5)
   ) dut (
      .InClock  (InClock),
      .reset    (reset),
      .run      (run),
      .clear    (clear),
      .div_load (divLoad),
      .div_in   (divIn),
      .tick     (tick),
      .square   (square),
      .div_err  (divErr)
   );

   initial InClock = 1'b0;
   always #5 InClock = ~InClock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, got running, need finished");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, expv, $time);
      end
   endtask

   // Sample point sits 1 time unit after the active edge.
   task automatic stepEdge();
      @(posedge InClock);
      #1;
   endtask

   initial begin
      reset   = 1'b1;
      run     = 2'b01;
      clear   = 2'b00;
      divLoad = 2'b00;
      divIn   = 8'd0;

      // Reset state and first periods with DEFAULT_DIVISOR = 5.
      repeat (2) stepEdge();
      check("reset_tick", 32'(tick), 32'd0);
      check("reset_square", 32'(square), 32'd0);
      check("reset_div_err", 32'(divErr), 32'd0);
      #3 reset = 1'b0;
      for (int k = 1; k <= 16; k++) begin
         stepEdge();
         check("d5_tick0", 32'(tick[0]), 32'((k % 5) == 0));
         check("d5_square0", 32'(square[0]), 32'((k / 5) % 2));
         check("d5_tick1_idle", 32'(tick[1]), 32'd0);
      end

      // D = 4, reload to 2 while count = 1; current period completes with 4.
      clear = 2'b01; divLoad = 2'b01; divIn = 8'd4;
      stepEdge();
      clear = 2'b00; divLoad = 2'b00;
      check("clr_tick0", 32'(tick[0]), 32'd0);
      check("clr_square0", 32'(square[0]), 32'd0);
      stepEdge();
      check("d4_e1_tick0", 32'(tick[0]), 32'd0);
      divLoad = 2'b01; divIn = 8'd2;
      for (int k = 2; k <= 9; k++) begin
         stepEdge();
         divLoad = 2'b00;
         check("reload_tick0", 32'(tick[0]), 32'(k == 4 || k == 6 || k == 8));
      end

      // D = 6, pause at count = 3 for 7 cycles.
      clear = 2'b01; divLoad = 2'b01; divIn = 8'd6;
      stepEdge();
      clear = 2'b00; divLoad = 2'b00;
      repeat (3) stepEdge();
      run = 2'b00;
      for (int k = 0; k < 7; k++) begin
         stepEdge();
         check("pause_tick0", 32'(tick[0]), 32'd0);
         check("pause_square0", 32'(square[0]), 32'd0);
      end
      run = 2'b01;
      for (int k = 1; k <= 3; k++) begin
         stepEdge();
         check("resume_tick0", 32'(tick[0]), 32'(k == 3));
      end
      check("resume_square0", 32'(square[0]), 32'd1);

      // Pause exactly at count = D-1; tick comes on the first edge after resume.
      repeat (5) stepEdge();
      run = 2'b00;
      repeat (2) begin
         stepEdge();
         check("pause_wrap_tick0", 32'(tick[0]), 32'd0);
      end
      run = 2'b01;
      stepEdge();
      check("resume_wrap_tick0", 32'(tick[0]), 32'd1);
      check("resume_wrap_square0", 32'(square[0]), 32'd0);

      // Channel 1: run with D = 5, then clear with load 3 at count = 2.
      run = 2'b11;
      for (int k = 1; k <= 7; k++) begin
         stepEdge();
         check("ch1_tick1", 32'(tick[1]), 32'(k == 5));
      end
      check("ch1_square1", 32'(square[1]), 32'd1);
      clear = 2'b10; divLoad = 2'b10; divIn = 8'd3;
      stepEdge();
      clear = 2'b00; divLoad = 2'b00;
      check("ch1_clr_square1", 32'(square[1]), 32'd0);
      check("ch1_clr_tick1", 32'(tick[1]), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         stepEdge();
         check("ch1_d3_tick1", 32'(tick[1]), 32'(k == 3));
      end

      // Zero divisor load on channel 0 (D = 6): ignored, div_err sticks.
      // Then a load of 2 coinciding with the wrap at k = 18 only becomes pending.
      clear = 2'b01;
      stepEdge();
      clear = 2'b00;
      for (int k = 1; k <= 18; k++) begin
         stepEdge();
         divLoad = 2'b00;
         check("zero_tick0", 32'(tick[0]), 32'((k % 6) == 0));
         check("zero_div_err", 32'(divErr), 32'(k >= 2));
         if (k == 1) begin
            divLoad = 2'b01; divIn = 8'd0;
         end
         if (k == 17) begin
            divLoad = 2'b01; divIn = 8'd2;
         end
      end
      check("pre_reset_square0", 32'(square[0]), 32'd1);

      // Asynchronous reset mid-cycle.
      #2 reset = 1'b1;
      run = 2'b01;
      #1;
      check("async_tick", 32'(tick), 32'd0);
      check("async_square", 32'(square), 32'd0);
      check("async_div_err", 32'(divErr), 32'd0);
      stepEdge();
      #3 reset = 1'b0;
      for (int k = 1; k <= 11; k++) begin
         stepEdge();
         check("post_reset_tick0", 32'(tick[0]), 32'((k % 5) == 0));
         check("post_reset_tick1", 32'(tick[1]), 32'd0);
         check("post_reset_div_err", 32'(divErr), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
